switch_param_loader: RTL and testbench



---
 rtl/switch_param_loader_pkg.sv | 24 ++
 rtl/switch_param_loader_debounce_pulse.sv | 72 +++++++
 rtl/switch_param_loader.sv | 123 ++++++++++++
 tb/tb_switch_param_loader.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/switch_param_loader_pkg.sv
// -----------------------------------------------------------------------------
// switch_param_loader_pkg
//   Shared definitions for the switch/pushbutton parameter loader:
//   - stage_e    : loader FSM state, also driven out on Stage for LED display
//   - DEFAULT_*  : hardware debounce settings (10 ms at 100 MHz)
//   - SIM_DEBOUNCE : short debounce interval so simulations stay small
// -----------------------------------------------------------------------------
package switch_param_loader_pkg;

  // Encoding is visible on the Stage port; keep the numeric values fixed.
  typedef enum logic [1:0] {
    WAIT_X       = 2'd0,
    WAIT_Y       = 2'd1,
    OFFER        = 2'd2,
    STAGE_UNUSED = 2'd3
  } stage_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_CNT_W           = 20;
  localparam int DEFAULT_DATA_W          = 16;

  localparam int SIM_DEBOUNCE            = 4;

endpackage

// File: rtl/switch_param_loader_debounce_pulse.sv
// -----------------------------------------------------------------------------
// debounce_pulse
//   Turns a raw, bouncing, asynchronous pushbutton into a single-cycle press
//   pulse.  Two-flop synchronizer, then a counter that only accepts a new
//   level after it has differed from the accepted level for DEBOUNCE_CYCLES
//   consecutive cycles, then a rising-edge detector with a registered output.
//
//   Parameters:
//     DEBOUNCE_CYCLES  cycles a new level must persist before acceptance
//     CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   Ports:
//     Clk    in   system clock (rising edge)
//     Reset  in   synchronous, active-high reset
//     In     in   raw asynchronous button level, active high
//     Pulse  out  one-cycle pulse per accepted press (never on release)
// -----------------------------------------------------------------------------
module debounce_pulse
  import switch_param_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic Clk,
  input  logic Reset,
  input  logic In,
  output logic Pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btn_p0;
  logic             btn_p1;
  logic             stable;
  logic             stable_prev;
  logic [CNT_W-1:0] cnt;
  logic             pulse_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      btn_p0      <= 1'b0;
      btn_p1      <= 1'b0;
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      cnt         <= '0;
      pulse_q     <= 1'b0;
    end else begin
      // stage 0/1: metastability synchronizer
      btn_p0 <= In;
      btn_p1 <= btn_p0;

      // debounce: any return to the accepted level restarts the count, so
      // only an unbroken run of DEBOUNCE_CYCLES differing samples is accepted
      if (btn_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= btn_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end

      // edge detect: rising edge of the accepted level only, registered so
      // the pulse is glitch-free and exactly one cycle wide
      stable_prev <= stable;
      pulse_q     <= stable & ~stable_prev;
    end
  end

  assign Pulse = pulse_q;

endmodule

// File: rtl/switch_param_loader.sv
// -----------------------------------------------------------------------------
// switch_param_loader
//   User-input front end of the motion-search datapath.  Each debounced
//   button press captures the synchronized slide switches: the first press
//   loads X, the second loads Y, after which the pair is offered to the
//   datapath on a valid/ready handshake.  Presses during the offer are
//   dropped.
//
//   Parameters:
//     DEBOUNCE_CYCLES  button debounce interval in clock cycles
//     CNT_W            debounce counter width
//     DATA_W           switch / parameter width
//   Ports:
//     Clk         in   system clock (rising edge)
//     Reset       in   synchronous, active-high reset
//     BtnIn       in   raw asynchronous pushbutton, active high
//     SwIn        in   raw asynchronous slide switches
//     ParamX      out  captured X parameter (held until overwritten)
//     ParamY      out  captured Y parameter (held until overwritten)
//     ParamValid  out  X/Y pair offered to the datapath (registered)
//     ParamReady  in   datapath accepts the pair (ignored outside OFFER)
//     Stage       out  current FSM state for LED/display indication
// -----------------------------------------------------------------------------
module switch_param_loader
  import switch_param_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int DATA_W          = DEFAULT_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              BtnIn,
  input  logic [DATA_W-1:0] SwIn,
  output logic [DATA_W-1:0] ParamX,
  output logic [DATA_W-1:0] ParamY,
  output logic              ParamValid,
  input  logic              ParamReady,
  output logic [1:0]        Stage
);

  logic [DATA_W-1:0] sw_p0;
  logic [DATA_W-1:0] sw_p1;
  logic              press;

  stage_e            state;
  stage_e            state_nxt;
  logic              valid_q;
  logic              valid_nxt;
  logic              cap_x;
  logic              cap_y;
  logic [DATA_W-1:0] param_x;
  logic [DATA_W-1:0] param_y;

  debounce_pulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn (
    .Clk   (Clk),
    .Reset (Reset),
    .In    (BtnIn),
    .Pulse (press)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      // stage 0/1: switch synchronizer; only sw_p1 is ever captured
      sw_p0 <= SwIn;
      sw_p1 <= sw_p0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= WAIT_X;
      valid_q <= 1'b0;
      param_x <= '0;
      param_y <= '0;
    end else begin
      state   <= state_nxt;
      valid_q <= valid_nxt;
      if (cap_x) param_x <= sw_p1;
      if (cap_y) param_y <= sw_p1;
    end
  end

  always_comb begin
    state_nxt = state;
    cap_x     = 1'b0;
    cap_y     = 1'b0;
    case (state)
      WAIT_X: begin
        if (press) begin
          cap_x     = 1'b1;
          state_nxt = WAIT_Y;
        end
      end
      WAIT_Y: begin
        if (press) begin
          cap_y     = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        // press is deliberately not looked at here: it is dropped
        if (valid_q && ParamReady) state_nxt = WAIT_X;
      end
      default: state_nxt = WAIT_X;
    endcase
    // valid is registered from the next state, so it is high on the very
    // first OFFER cycle and falls together with the handshake
    valid_nxt = (state_nxt == OFFER);
  end

  assign ParamX     = param_x;
  assign ParamY     = param_y;
  assign ParamValid = valid_q;
  assign Stage      = state;

endmodule

// File: tb/tb_switch_param_loader.sv
module tb_switch_param_loader;
  import switch_param_loader_pkg::*;

  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          BtnIn;
  logic [DW-1:0] SwIn;
  logic [DW-1:0] ParamX;
  logic [DW-1:0] ParamY;
  logic          ParamValid;
  logic          ParamReady;
  logic [1:0]    Stage;

  int n_assert = 0;
  int n_fail   = 0;
  int n_hs     = 0;

  // expected {X,Y} pairs, pushed when the Y press is driven
  logic [31:0] exp_q[$];

  switch_param_loader #(
    .DEBOUNCE_CYCLES (SIM_DEBOUNCE),
    .CNT_W           (4),
    .DATA_W          (DW)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .BtnIn      (BtnIn),
    .SwIn       (SwIn),
    .ParamX     (ParamX),
    .ParamY     (ParamY),
    .ParamValid (ParamValid),
    .ParamReady (ParamReady),
    .Stage      (Stage)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Scoreboard: a handshake completes on the edge following a negedge where
  // valid and ready are both high; compare the offered pair there.
  always @(negedge Clk) begin
    if (!Reset && ParamValid && ParamReady) begin
      n_hs++;
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("sb_pair", {ParamX, ParamY}, exp_q.pop_front());
    end
  end

  logic bounce [7];

  initial begin
    Reset      = 1'b1;
    BtnIn      = 1'b0;
    SwIn       = '0;
    ParamReady = 1'b0;
    bounce     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // 1: reset held, then released with the button idle
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_outputs", {ParamX, ParamY, ParamValid, Stage}, 64'd0);
    end
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("rst_release", {ParamX, ParamY, ParamValid, Stage}, 64'd0);
    end

    // 2: first press captures X at edge E+7
    SwIn  = 16'h0012;
    BtnIn = 1'b1;
    tick(7);
    check("x_not_early", {ParamX, Stage}, {16'h0000, 2'd0});
    tick(1);
    check("x_capture", {ParamX, Stage}, {16'h0012, 2'd1});
    tick(12);
    check("x_hold_one_press", Stage, 2'd1);
    BtnIn = 1'b0;
    tick(12);
    check("x_release_no_press", {ParamX, Stage}, {16'h0012, 2'd1});

    // 3: second press captures Y; offer held while ParamReady is low
    SwIn = 16'h0034;
    exp_q.push_back({16'h0012, 16'h0034});
    BtnIn = 1'b1;
    tick(8);
    check("y_capture", {ParamY, Stage, ParamValid}, {16'h0034, 2'd2, 1'b1});
    BtnIn = 1'b0;
    SwIn  = 16'hffff;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) BtnIn = 1'b1;
      if (i == 25) BtnIn = 1'b0;
      tick(1);
      check("offer_valid_held", {ParamValid, Stage}, {1'b1, 2'd2});
    end
    check("offer_press_dropped", {ParamX, ParamY}, {16'h0012, 16'h0034});

    // 4: one-cycle ready completes the handshake
    ParamReady = 1'b1;
    tick(1);
    ParamReady = 1'b0;
    check("hs_valid_drop", {ParamValid, Stage}, {1'b0, 2'd0});
    check("hs_params_kept", {ParamX, ParamY}, {16'h0012, 16'h0034});
    tick(10);
    check("hs_no_queued_press", {Stage, ParamX}, {2'd0, 16'h0012});

    // 5: bounce without a 4-cycle run, then a steady press
    SwIn = 16'h00ab;
    for (int i = 0; i < 7; i++) begin
      BtnIn = bounce[i];
      tick(1);
    end
    BtnIn = 1'b0;
    tick(10);
    check("bounce_ignored", {Stage, ParamX}, {2'd0, 16'h0012});
    BtnIn = 1'b1;
    tick(20);
    check("steady_press", {Stage, ParamX}, {2'd1, 16'h00ab});
    BtnIn = 1'b0;
    tick(12);
    check("steady_one_press", Stage, 2'd1);

    // 6: reset in WAIT_Y with the button held, press reappears after release
    SwIn  = 16'h5a5a;
    BtnIn = 1'b1;
    tick(2);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("midrst_outputs", {ParamX, ParamY, ParamValid, Stage}, 64'd0);
    end
    Reset = 1'b0;
    tick(7);
    check("midrst_not_early", {ParamX, Stage}, {16'h0000, 2'd0});
    tick(1);
    check("midrst_capture", {ParamX, Stage}, {16'h5a5a, 2'd1});
    BtnIn = 1'b0;
    tick(12);

    // ready already high on entry to OFFER: valid lasts exactly one cycle
    ParamReady = 1'b1;
    SwIn = 16'h0c0c;
    exp_q.push_back({16'h5a5a, 16'h0c0c});
    BtnIn = 1'b1;
    tick(8);
    check("rdy_entry_offer", {ParamY, Stage, ParamValid}, {16'h0c0c, 2'd2, 1'b1});
    tick(1);
    check("rdy_entry_done", {ParamValid, Stage}, {1'b0, 2'd0});
    ParamReady = 1'b0;
    BtnIn = 1'b0;
    tick(12);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("hs_count", 64'(n_hs), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
